// File: rtl/alu_seq_pkg.sv
// ============================================================================
// Module      : alu_seq_pkg
// Description : Opcode/state types and opcode legality for alu_seq.
//               Optional DIV support is selected by ALU_SEQ_DIV_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_seq_pkg;

    typedef enum logic [3:0] {
        OP_ADD = 4'd0,
        OP_SUB = 4'd1,
        OP_AND = 4'd2,
        OP_OR  = 4'd3,
        OP_XOR = 4'd4,
        OP_NOT = 4'd5,
        OP_SHL = 4'd6,
        OP_SHR = 4'd7,
        OP_MUL = 4'd8,
        OP_DIV = 4'd9
    } opcode_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_e;

    function automatic logic opcode_is_legal(input logic [3:0] op);
`ifdef ALU_SEQ_DIV_EN
        return (op <= OP_DIV);
`else
        return (op <= OP_MUL);
`endif
    endfunction

endpackage

`default_nettype wire

// File: rtl/alu_seq_muldiv.sv
// ============================================================================
// Module      : alu_seq_muldiv
// Description : Iterative N-step datapath: LSB-first shift-add multiplier
//               (mode=0) or restoring divider (mode=1).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_seq_muldiv
    import alu_seq_pkg::*;
#(
    parameter int N = 4
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    input  logic           mode,
    output logic           busy,
    output logic           done,
    output logic [2*N-1:0] result
);

    localparam int                  c_cnt_w    = $clog2(N + 1);
    localparam logic [c_cnt_w-1:0]  c_cnt_init = c_cnt_w'(N);
    localparam logic [c_cnt_w-1:0]  c_cnt_one  = c_cnt_w'(1);

    logic               r_busy;
    logic               r_mode;
    logic [c_cnt_w-1:0] r_count;
    logic [2*N-1:0]     r_acc;
    logic [2*N-1:0]     r_mcand;
    logic [N-1:0]       r_mplier;
    logic [N-1:0]       r_rem;
    logic [N-1:0]       r_quo;
    logic [N-1:0]       r_dvs;

    logic [2*N-1:0]     w_acc_next;
    logic [N:0]         w_shift;
    logic               w_ge;
    logic [N-1:0]       w_trial;
    logic [N-1:0]       w_rem_next;
    logic [N-1:0]       w_quo_next;

    always_comb begin
        w_acc_next = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
        // Restoring step: the dividend shifts out of r_quo MSB-first while
        // quotient bits shift in at the LSB.
        w_shift    = {r_rem, r_quo[N-1]};
        w_ge       = (w_shift >= {1'b0, r_dvs});
        w_trial    = w_shift[N-1:0] - r_dvs;
        w_rem_next = w_ge ? w_trial : w_shift[N-1:0];
        w_quo_next = {r_quo[N-2:0], w_ge};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_busy   <= 1'b0;
            r_mode   <= 1'b0;
            r_count  <= '0;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_rem    <= '0;
            r_quo    <= '0;
            r_dvs    <= '0;
        end else if (start) begin
            r_busy   <= 1'b1;
            r_mode   <= mode;
            r_count  <= c_cnt_init;
            r_acc    <= '0;
            r_mcand  <= {{N{1'b0}}, a};
            r_mplier <= b;
            r_rem    <= '0;
            r_quo    <= a;
            r_dvs    <= b;
        end else if (r_busy) begin
            r_acc    <= w_acc_next;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_rem    <= w_rem_next;
            r_quo    <= w_quo_next;
            r_count  <= r_count - c_cnt_one;
            if (r_count == c_cnt_one) begin
                r_busy <= 1'b0;
            end
        end
    end

    // done flags the cycle whose edge performs the last step; result is the
    // value that step produces, so the caller can register it on that edge.
    assign busy   = r_busy;
    assign done   = r_busy && (r_count == c_cnt_one);
    assign result = r_mode ? {w_rem_next, w_quo_next} : w_acc_next;

endmodule

`default_nettype wire

// File: rtl/alu_seq.sv
// ============================================================================
// Module      : alu_seq
// Description : Handshaked multi-cycle N-bit ALU with status flags and result
//               hold. Define ALU_SEQ_DIV_EN to enable opcode 9 (DIV).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int N         = 4,
    parameter int MUL_STEPS = N
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N-1:0]   operand1,
    input  logic [N-1:0]   operand2,
    input  logic [3:0]     operation,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*N-1:0] alu_out,
    output logic           zero,
    output logic           carry,
    output logic           illegal
);

    generate
        if (MUL_STEPS != N || N < 2) begin : g_param_check
            $error("alu_seq: requires N >= 2 and MUL_STEPS == N");
        end
    endgenerate

    state_e         r_state;
    state_e         w_next;
    logic [2*N-1:0] r_alu_out;
    logic           r_zero;
    logic           r_carry;
    logic           r_illegal;
    logic           r_div0;

    logic           w_accept;
    logic           w_md_op;
    logic           w_md_start;
    logic           w_md_mode;
    logic           w_md_busy;
    logic           w_md_done;
    logic [2*N-1:0] w_md_result;

    logic [N:0]     w_sum;
    logic [N:0]     w_diff;
    logic [2*N-1:0] w_res;
    logic           w_carry;
    logic           w_illegal;

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign alu_out   = r_alu_out;
    assign zero      = r_zero;
    assign carry     = r_carry;
    assign illegal   = r_illegal;

    assign w_accept  = in_valid && in_ready;
`ifdef ALU_SEQ_DIV_EN
    assign w_md_op   = (operation == OP_MUL) || (operation == OP_DIV);
`else
    assign w_md_op   = (operation == OP_MUL);
`endif
    assign w_md_start = w_accept && w_md_op;
    assign w_md_mode  = (operation == OP_DIV);

    alu_seq_muldiv #(
        .N      (N)
    ) u_muldiv (
        .clk    (clk),
        .reset  (reset),
        .start  (w_md_start),
        .a      (operand1),
        .b      (operand2),
        .mode   (w_md_mode),
        .busy   (w_md_busy),
        .done   (w_md_done),
        .result (w_md_result)
    );

    // Single-cycle operations, evaluated straight from the accepted inputs.
    always_comb begin
        w_sum     = {1'b0, operand1} + {1'b0, operand2};
        w_diff    = {1'b0, operand1} - {1'b0, operand2};
        w_res     = '0;
        w_carry   = 1'b0;
        w_illegal = !opcode_is_legal(operation);
        case (operation)
            OP_ADD: begin
                w_res   = {{(N-1){1'b0}}, w_sum};
                w_carry = w_sum[N];
            end
            OP_SUB: begin
                w_res   = {{N{1'b0}}, w_diff[N-1:0]};
                w_carry = w_diff[N];
            end
            OP_AND:  w_res = {{N{1'b0}}, operand1 & operand2};
            OP_OR:   w_res = {{N{1'b0}}, operand1 | operand2};
            OP_XOR:  w_res = {{N{1'b0}}, operand1 ^ operand2};
            OP_NOT:  w_res = {{N{1'b0}}, ~operand1};
            OP_SHL:  w_res = {{N{1'b0}}, operand1} << operand2;
            OP_SHR:  w_res = {{N{1'b0}}, operand1 >> operand2};
            default: w_res = '0;
        endcase
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (operation == OP_MUL) w_next = MUL;
`ifdef ALU_SEQ_DIV_EN
                    else if (operation == OP_DIV) w_next = DIV;
`endif
                    else w_next = DONE;
                end
            end
            MUL, DIV: begin
                if (w_md_done) w_next = DONE;
            end
            DONE: begin
                if (out_ready) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            if (r_state == MUL || r_state == DIV) begin
                assert (w_md_busy);
            end
            r_state <= w_next;
        end
    end

    // Result and flags are written only on completion, so they hold in DONE.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_alu_out <= '0;
            r_zero    <= 1'b0;
            r_carry   <= 1'b0;
            r_illegal <= 1'b0;
            r_div0    <= 1'b0;
        end else begin
            if (w_accept) begin
                r_div0 <= (operand2 == '0);
            end
            if (w_accept && !w_md_op) begin
                r_alu_out <= w_res;
                r_zero    <= (w_res == '0);
                r_carry   <= w_carry;
                r_illegal <= w_illegal;
            end else if (w_md_done) begin
                r_alu_out <= w_md_result;
                r_zero    <= (w_md_result == '0);
                r_carry   <= 1'b0;
                r_illegal <= (r_state == DIV) && r_div0;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_alu_seq.sv
// ============================================================================
// Module      : tb_alu_seq
// Description : Self-checking bench for alu_seq: directed literal cases plus
//               randomized traffic against a transaction-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_seq;

    localparam int N = 4;
    localparam int W = 2 * N;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] operand1;
    logic [N-1:0] operand2;
    logic [3:0]   operation;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] alu_out;
    logic         zero;
    logic         carry;
    logic         illegal;

    int errors = 0;
    int checks = 0;

    alu_seq #(
        .N         (N),
        .MUL_STEPS (N)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .operand1  (operand1),
        .operand2  (operand2),
        .operation (operation),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .alu_out   (alu_out),
        .zero      (zero),
        .carry     (carry),
        .illegal   (illegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out waiting for DUT (t=%0t)", name, $time);
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [W-1:0] res;
        logic         c;
        logic         ill;
        logic [7:0]   lat;
    } exp_t;

    function automatic exp_t model_op(input int op, input int a, input int b);
        exp_t e;
        int   r;
        e.c   = 1'b0;
        e.ill = 1'b0;
        e.lat = 8'd1;
        r     = 0;
        case (op)
            0: begin r = a + b; e.c = (r >= (1 << N)); end
            1: begin r = (a - b + (1 << N)) % (1 << N); e.c = (a < b); end
            2: r = a & b;
            3: r = a | b;
            4: r = a ^ b;
            5: r = (~a) & ((1 << N) - 1);
            6: r = (b >= W) ? 0 : ((a << b) & ((1 << W) - 1));
            7: r = (b >= N) ? 0 : (a >> b);
            8: begin r = a * b; e.lat = 8'(N + 1); end
`ifdef ALU_SEQ_DIV_EN
            9: begin
                e.lat = 8'(N + 1);
                if (b == 0) begin
                    r     = (a << N) | ((1 << N) - 1);
                    e.ill = 1'b1;
                end else begin
                    r = ((a % b) << N) | (a / b);
                end
            end
`endif
            default: e.ill = 1'b1;
        endcase
        e.res = W'(r);
        return e;
    endfunction

    // One outstanding transaction: idle -> pending (countdown) -> valid.
    bit   m_idle        = 1'b1;
    bit   m_valid       = 1'b0;
    bit   m_after_reset = 1'b1;
    int   m_wait        = 0;
    exp_t m_e           = '0;

    always @(negedge clk) begin
        if (m_after_reset) begin
            chk("reset_alu_out", alu_out, 0);
            chk("reset_flags", {zero, carry, illegal}, 3'b000);
        end
        chk("model_in_ready", in_ready, m_idle);
        chk("model_out_valid", out_valid, m_valid);
        if (m_valid) begin
            chk("model_alu_out", alu_out, m_e.res);
            chk("model_flags", {zero, carry, illegal}, {(m_e.res == '0), m_e.c, m_e.ill});
        end
        m_after_reset = 1'b0;
        if (reset) begin
            m_idle        = 1'b1;
            m_valid       = 1'b0;
            m_after_reset = 1'b1;
        end else if (m_idle) begin
            if (in_valid) begin
                m_e     = model_op(int'(operation), int'(operand1), int'(operand2));
                m_idle  = 1'b0;
                m_wait  = int'(m_e.lat) - 1;
                m_valid = (m_wait == 0);
            end
        end else if (!m_valid) begin
            m_wait--;
            m_valid = (m_wait == 0);
        end else if (out_ready) begin
            m_valid = 1'b0;
            m_idle  = 1'b1;
        end
    end

    // ---------------- directed helpers ----------------
    task automatic wait_accept(input string name);
        bit got = 1'b0;
        for (int k = 0; k < 50 && !got; k++) begin
            @(negedge clk);
            got = in_ready;
            @(posedge clk);
            #1;
        end
        if (!got) timeout({name, "_accept"});
    endtask

    task automatic wait_result(input string name, input logic [W-1:0] er,
                               input bit ez, input bit ec, input bit ei, input int elat);
        int cyc = 0;
        bit got = 1'b0;
        for (int k = 0; k < 50 && !got; k++) begin
            @(negedge clk);
            cyc++;
            if (out_valid) begin
                got = 1'b1;
            end else begin
                chk({name, "_busy_in_ready"}, in_ready, 0);
                @(posedge clk);
                #1;
                operand1 = N'($urandom);
                operand2 = N'($urandom);
            end
        end
        if (!got) begin
            timeout({name, "_result"});
        end else begin
            chk({name, "_latency"}, cyc, elat);
            chk({name, "_alu_out"}, alu_out, er);
            chk({name, "_flags"}, {zero, carry, illegal}, {ez, ec, ei});
            chk({name, "_done_in_ready"}, in_ready, 0);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic run_op(input string name, input logic [3:0] op, input logic [N-1:0] a,
                          input logic [N-1:0] b, input logic [W-1:0] er,
                          input bit ez, input bit ec, input bit ei, input int elat);
        operation = op;
        operand1  = a;
        operand2  = b;
        in_valid  = 1'b1;
        wait_accept(name);
        in_valid  = 1'b0;
        wait_result(name, er, ez, ec, ei, elat);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        operand1  = '0;
        operand2  = '0;
        operation = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        run_op("add_carry", 4'd0, 4'hF, 4'h1, 8'h10, 0, 1, 0, 1);
        run_op("sub_borrow", 4'd1, 4'h3, 4'h5, 8'h0E, 0, 1, 0, 1);
        run_op("sub_zero", 4'd1, 4'h5, 4'h5, 8'h00, 1, 0, 0, 1);
        run_op("mul_ff", 4'd8, 4'hF, 4'hF, 8'hE1, 0, 0, 0, N + 1);
        run_op("shl_edge", 4'd6, 4'h9, 4'h7, 8'h80, 0, 0, 0, 1);
        run_op("shl_over", 4'd6, 4'hF, 4'h8, 8'h00, 1, 0, 0, 1);
        run_op("shr_over", 4'd7, 4'hF, 4'h4, 8'h00, 1, 0, 0, 1);
        run_op("illegal_c", 4'hC, 4'h7, 4'h2, 8'h00, 1, 0, 1, 1);
`ifdef ALU_SEQ_DIV_EN
        run_op("div_13_3", 4'd9, 4'hD, 4'h3, 8'h14, 0, 0, 0, N + 1);
        run_op("div_by0", 4'd9, 4'hD, 4'h0, 8'hDF, 0, 0, 1, N + 1);
`else
        run_op("div_off", 4'd9, 4'hD, 4'h3, 8'h00, 1, 0, 1, 1);
`endif

        // Backpressure: result must hold and a pending request must wait.
        out_ready = 1'b0;
        operation = 4'd2;
        operand1  = 4'hA;
        operand2  = 4'hC;
        in_valid  = 1'b1;
        wait_accept("bp_and");
        operation = 4'd3;
        operand1  = 4'h5;
        operand2  = 4'hA;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("bp_out_valid", out_valid, 1);
            chk("bp_alu_out", alu_out, 8'h08);
            chk("bp_in_ready", in_ready, 0);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        wait_accept("bp_or");
        in_valid = 1'b0;
        wait_result("bp_or", 8'h0F, 0, 0, 0, 1);

        // Reset during a MUL aborts it without a result.
        operation = 4'd8;
        operand1  = 4'h7;
        operand2  = 4'h9;
        in_valid  = 1'b1;
        wait_accept("rst_mul");
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("rst_mul_in_ready", in_ready, 1);
        chk("rst_mul_out_valid", out_valid, 0);
        chk("rst_mul_alu_out", alu_out, 0);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("rst_mul_no_stale", out_valid, 0);
        end
        @(posedge clk);
        #1;

        // Randomized traffic; the model process checks every cycle.
        for (int i = 0; i < 3000; i++) begin
            reset     = ($urandom_range(0, 199) == 0);
            in_valid  = ($urandom_range(0, 1) == 1);
            operation = ($urandom_range(0, 3) == 0) ? 4'd8 : 4'($urandom_range(0, 15));
            operand1  = N'($urandom);
            operand2  = ($urandom_range(0, 7) == 0) ? '0 : N'($urandom);
            out_ready = ($urandom_range(0, 9) < 6);
            @(posedge clk);
            #1;
        end

        reset     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (20) @(posedge clk);
        #1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
